seg_frame_ctrl: RTL

- Upstream feeder for the serial 7-segment driver (SEG_DRV); converts a 32-bit hex value into a 64-bit active-low segment frame.
- Launches the driver with a one-cycle start pulse and tracks its finish handshake.
- Re-sends on value/dot/blank change, on force request, and on a periodic refresh timer; coalesces changes arriving mid-transfer into one follow-up frame.

---
 rtl/seg_frame_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_frame_ctrl.sv
// Frame feeder for the serial 7-segment driver: encodes a 32-bit hex value into a 64-bit active-low frame.
// Optional: define SEG_FRAME_LZ_BLANK_EN to suppress leading zero digits.
module seg_frame_ctrl #(
    parameter int REFRESH_CYCLES = 0,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  dot,
    input  logic [7:0]  blank,
    input  logic        force_update,
    input  logic        finish,
    output logic        start,
    output logic [63:0] seg_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t state;
    state_t next_state;

    logic [31:0]      snap_value;
    logic [7:0]       snap_dot;
    logic [7:0]       snap_blank;
    logic [31:0]      prev_value;
    logic [7:0]       prev_dot;
    logic [7:0]       prev_blank;
    logic             snap_valid;
    logic             prev_valid;
    logic             change;

    logic             pending;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_hit;
    logic [ACK_W-1:0] ack_cnt;
    logic             ack_hit;

    logic [2:0]       digit_cnt;
    logic [31:0]      work_value;
    logic [7:0]       work_dot;
    logic [7:0]       work_blank;
    logic [7:0]       lz_mask;
    logic [3:0]       cur_nibble;
    logic [7:0]       hex_byte;
    logic [7:0]       enc_byte;

    // Change detection only arms once both snapshot stages hold real samples,
    // so reset release alone never queues a second frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_value <= '0;
            snap_dot   <= '0;
            snap_blank <= '0;
            prev_value <= '0;
            prev_dot   <= '0;
            prev_blank <= '0;
            snap_valid <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            snap_value <= value;
            snap_dot   <= dot;
            snap_blank <= blank;
            prev_value <= snap_value;
            prev_dot   <= snap_dot;
            prev_blank <= snap_blank;
            snap_valid <= 1'b1;
            prev_valid <= snap_valid;
        end
    end

    assign change  = prev_valid &&
                     ({snap_value, snap_dot, snap_blank} != {prev_value, prev_dot, prev_blank});
    assign ref_hit = (REFRESH_CYCLES != 0) && (state == IDLE) && !pending &&
                     (ref_cnt == REF_W'(REFRESH_CYCLES - 1));
    assign ack_hit = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

    // A request arriving while a frame is consumed wins, so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b1;
        end else if (change || force_update || ref_hit) begin
            pending <= 1'b1;
        end else if (state == IDLE) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            ack_cnt <= '0;
        end else begin
            if (state != IDLE || pending || ref_hit) begin
                ref_cnt <= '0;
            end else if (REFRESH_CYCLES != 0) begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            if (state != WAIT_ACK) begin
                ack_cnt <= '0;
            end else begin
                ack_cnt <= ack_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (pending) next_state = ENCODE;
            ENCODE:    if (digit_cnt == 3'd7) next_state = LAUNCH;
            LAUNCH:    next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (!finish) begin
                    next_state = WAIT_DONE;
                end else if (ack_hit) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: if (finish) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        start = (state == LAUNCH);
        busy  = (state != IDLE);
    end

`ifdef SEG_FRAME_LZ_BLANK_EN
    logic lz_seen;

    always_comb begin
        lz_mask = '0;
        lz_seen = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            lz_seen    = lz_seen | (work_value[4*i +: 4] != 4'h0);
            lz_mask[i] = !lz_seen;
        end
    end
`else
    assign lz_mask = 8'h00;
`endif

    always_comb begin
        cur_nibble = work_value[{digit_cnt, 2'b00} +: 4];
        case (cur_nibble)
            4'h0: hex_byte = 8'hC0;
            4'h1: hex_byte = 8'hF9;
            4'h2: hex_byte = 8'hA4;
            4'h3: hex_byte = 8'hB0;
            4'h4: hex_byte = 8'h99;
            4'h5: hex_byte = 8'h92;
            4'h6: hex_byte = 8'h82;
            4'h7: hex_byte = 8'hF8;
            4'h8: hex_byte = 8'h80;
            4'h9: hex_byte = 8'h90;
            4'hA: hex_byte = 8'h88;
            4'hB: hex_byte = 8'h83;
            4'hC: hex_byte = 8'hC6;
            4'hD: hex_byte = 8'hA1;
            4'hE: hex_byte = 8'h86;
            default: hex_byte = 8'h8E;
        endcase
        enc_byte = hex_byte;
        if (work_dot[digit_cnt]) enc_byte[7] = 1'b0;
        if (lz_mask[digit_cnt] || work_blank[digit_cnt]) enc_byte = 8'hFF;
    end

    // Working copy is taken from the inputs being snapshotted on this same edge,
    // so the very first frame after reset already carries the live value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_cnt  <= '0;
            work_value <= '0;
            work_dot   <= '0;
            work_blank <= '0;
            seg_data   <= '1;
        end else begin
            if (state == IDLE && pending) begin
                work_value <= value;
                work_dot   <= dot;
                work_blank <= blank;
                digit_cnt  <= '0;
            end else if (state == ENCODE) begin
                seg_data[{digit_cnt, 3'b000} +: 8] <= enc_byte;
                digit_cnt <= digit_cnt + 3'd1;
            end
        end
    end

endmodule
